// File: rtl/cgra_col_exec_ctrl.sv
// rtl/cgra_col_exec_ctrl.sv - per-column CGRA execution controller (optional CGRA_COL_CYCLE_CNT_EN)
module cgra_col_exec_ctrl #(
    parameter int N_COL      = 4,
    parameter int COL_IDX    = 0,
    parameter int IMEM_AW    = 5,
    parameter int KMEM_WIDTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_COL-1:0]      acc_req_i,
    input  logic [KMEM_WIDTH-1:0] conf_word_i,
    input  logic                  col_stall_i,
    input  logic [N_COL-1:0]      peer_done_i,
    output logic                  acc_ack_o,
    output logic                  col_start_o,
    output logic                  imem_en_o,
    output logic [IMEM_AW-1:0]    imem_addr_o,
    output logic                  col_done_o,
    output logic                  acc_end_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      run_cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE,
        S_END
    } state_t;

    // Bits below our own column; if none of them is in the group map we lead the group.
    localparam logic [N_COL-1:0] LOW_MASK = N_COL'((64'd1 << COL_IDX) - 64'd1);

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q;
    logic [IMEM_AW-1:0] start_q;
    logic [IMEM_AW-1:0] end_q;
    logic [N_COL-1:0]   map_q;
    logic               is_leader;
    logic               group_done;
    logic               last_fetch;

    assign is_leader   = (map_q & LOW_MASK) == '0;
    assign group_done  = (peer_done_i & map_q) == map_q;
    assign last_fetch  = !col_stall_i && (pc_q == end_q);
    assign imem_addr_o = pc_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; fetch enable is the only output that follows stall in-cycle.
    always_comb begin
        state_d     = state_q;
        acc_ack_o   = 1'b0;
        col_start_o = 1'b0;
        imem_en_o   = 1'b0;
        col_done_o  = 1'b0;
        acc_end_o   = 1'b0;
        busy_o      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (acc_req_i[COL_IDX]) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                acc_ack_o   = 1'b1;
                col_start_o = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                imem_en_o = !col_stall_i;
                if (last_fetch) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                col_done_o = 1'b1;
                if (group_done) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                acc_end_o = is_leader;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Kernel bounds, group map and program counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            start_q <= '0;
            end_q   <= '0;
            map_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc_req_i[COL_IDX]) begin
                        start_q <= conf_word_i[IMEM_AW-1:0];
                        end_q   <= conf_word_i[2*IMEM_AW-1:IMEM_AW];
                        map_q   <= acc_req_i;
                    end
                end
                S_START: pc_q <= start_q;
                S_RUN: begin
                    if (!col_stall_i && (pc_q != end_q)) begin
                        pc_q <= pc_q + IMEM_AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        if (KMEM_WIDTH > 2 * IMEM_AW) begin : g_unused_conf
            logic unused_conf;
            assign unused_conf = ^conf_word_i[KMEM_WIDTH-1:2*IMEM_AW];
        end
    endgenerate

`ifdef CGRA_COL_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating RUN-cycle counter, cleared on each kernel start and held otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == S_START) begin
            cnt_q <= '0;
        end else if ((state_q == S_RUN) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign run_cycles_o = cnt_q;
`else
    assign run_cycles_o = '0;
`endif

endmodule
